// File: rtl/counter_event_monitor_if.sv
//------------------------------------------------------------------------------
// Module  : counter_event_monitor_if
// Brief   : Bus-sample, compare-config and capture-FIFO signals of the monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface counter_event_monitor_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
);
  logic [WIDTH-1:0] bus_q;
  logic             bus_en;
  logic             cmp_we;
  logic [WIDTH-1:0] cmp_data;
  logic             trig;
  logic             ovf_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             match;
  logic             wrap;
  logic             ovf;

  modport master (
    output bus_q, bus_en, cmp_we, cmp_data, trig, ovf_clr, out_ready,
    input  out_valid, out_data, level, match, wrap, ovf
  );

  modport slave (
    input  bus_q, bus_en, cmp_we, cmp_data, trig, ovf_clr, out_ready,
    output out_valid, out_data, level, match, wrap, ovf
  );
endinterface

`default_nettype wire

// File: rtl/counter_event_monitor.sv
//------------------------------------------------------------------------------
// Module  : counter_event_monitor
// Brief   : Samples a tri-stated counter bus, flags compare/wrap, captures to FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_event_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  counter_event_monitor_if.slave mon
);
  localparam int              LW         = $clog2(DEPTH) + 1;
  localparam int              PW         = $clog2(DEPTH);
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] r_s_q;
  logic             r_s_vld;
  logic             r_s_trig;
  logic [WIDTH-1:0] r_last_q;
  logic             r_last_vld;
  logic [WIDTH-1:0] r_cmp;
  logic             r_match;
  logic             r_wrap;
  logic             r_ovf;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_full = (r_level == FULL_LEVEL);
  assign w_pop  = (r_level != '0) & mon.out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr   = r_s_trig & (~w_full | w_pop);
  assign w_drop = r_s_trig & w_full & ~w_pop;

  // Sample stage: bus_q is only trusted while bus_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q    <= '0;
      r_s_vld  <= 1'b0;
      r_s_trig <= 1'b0;
    end else begin
      r_s_vld  <= mon.bus_en;
      r_s_trig <= mon.trig & mon.bus_en;
      if (mon.bus_en) begin
        r_s_q <= mon.bus_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp      <= '0;
      r_match    <= 1'b0;
      r_wrap     <= 1'b0;
      r_last_q   <= '0;
      r_last_vld <= 1'b0;
    end else begin
      if (mon.cmp_we) begin
        r_cmp <= mon.cmp_data;
      end
      r_match <= r_s_vld & (r_s_q == r_cmp);
      r_wrap  <= r_s_vld & r_last_vld & (&r_last_q) & (r_s_q == '0);
      if (r_s_vld) begin
        r_last_q   <= r_s_q;
        r_last_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_s_q;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // A new drop outranks a simultaneous clear.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (mon.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign mon.out_valid = (r_level != '0);
  assign mon.out_data  = r_mem[r_rptr];
  assign mon.level     = r_level;
  assign mon.match     = r_match;
  assign mon.wrap      = r_wrap;
  assign mon.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_counter_event_monitor.sv
//------------------------------------------------------------------------------
// Module  : tb_counter_event_monitor
// Brief   : Directed self-checking bench for counter_event_monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_event_monitor;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  counter_event_monitor_if #(.WIDTH(8), .DEPTH(4)) u_if ();

  counter_event_monitor #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (u_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input logic en, input logic t);
    u_if.bus_q  = en ? v : 8'hzz;
    u_if.bus_en = en;
    u_if.trig   = t;
    tick();
  endtask

  task automatic test_reset();
    u_if.bus_q     = 8'hzz;
    u_if.bus_en    = 1'b0;
    u_if.cmp_we    = 1'b0;
    u_if.cmp_data  = 8'h00;
    u_if.trig      = 1'b0;
    u_if.ovf_clr   = 1'b0;
    u_if.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({u_if.out_valid, u_if.level, u_if.match, u_if.wrap, u_if.ovf} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_flags: got v=%b lvl=%0d m=%b w=%b o=%b want all 0",
               u_if.out_valid, u_if.level, u_if.match, u_if.wrap, u_if.ovf);
    end
    n_cmp++;
    if (u_if.out_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_out_data: got %h want 00", u_if.out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_count();
    logic [7:0] v [8];
    logic       en [8];
    logic       em [8];
    logic       ew [8];
    v  = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    em = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    u_if.cmp_we   = 1'b1;
    u_if.cmp_data = 8'h01;
    drive(8'h00, 1'b0, 1'b0);
    u_if.cmp_we   = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(v[i], en[i], 1'b0);
      n_cmp++;
      if (u_if.match !== em[i]) begin
        n_err++;
        $display("FAIL count_match[%0d]: got %b want %b", i, u_if.match, em[i]);
      end
      n_cmp++;
      if (u_if.wrap !== ew[i]) begin
        n_err++;
        $display("FAIL count_wrap[%0d]: got %b want %b", i, u_if.wrap, ew[i]);
      end
    end
  endtask

  task automatic test_gap_and_load();
    logic [7:0] v [12];
    logic       en [12];
    logic       ew [12];
    v  = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h80, 8'h00, 8'h00, 8'h00};
    en = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
           1'b1, 1'b1, 1'b0, 1'b0};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(v[i], en[i], 1'b0);
      n_cmp++;
      if (u_if.wrap !== ew[i]) begin
        n_err++;
        $display("FAIL gap_wrap[%0d]: got %b want %b", i, u_if.wrap, ew[i]);
      end
      n_cmp++;
      if ($isunknown({u_if.match, u_if.wrap, u_if.out_valid, u_if.level,
                      u_if.out_data, u_if.ovf}) !== 1'b0) begin
        n_err++;
        $display("FAIL gap_no_x[%0d]: got m=%b w=%b d=%h want no X",
                 i, u_if.match, u_if.wrap, u_if.out_data);
      end
    end
  endtask

  task automatic test_overflow();
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'h10 + 8'(i), 1'b1, 1'b1);
    end
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.level !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_level: got %0d want 4", u_if.level);
    end
    n_cmp++;
    if (u_if.ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got %b want 1", u_if.ovf);
    end
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'h10 + 8'(k)
          || u_if.level !== 3'(4 - k)) begin
        n_err++;
        $display("FAIL drain[%0d]: got v=%b d=%h lvl=%0d want v=1 d=%h lvl=%0d",
                 k, u_if.out_valid, u_if.out_data, u_if.level, 8'h10 + 8'(k), 4 - k);
      end
      tick();
    end
    n_cmp++;
    if (u_if.out_valid !== 1'b0 || u_if.level !== 3'd0) begin
      n_err++;
      $display("FAIL drain_empty: got v=%b lvl=%0d want v=0 lvl=0",
               u_if.out_valid, u_if.level);
    end
    tick();
    n_cmp++;
    if (u_if.level !== 3'd0) begin
      n_err++;
      $display("FAIL pop_empty: got lvl=%0d want 0", u_if.level);
    end
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    u_if.ovf_clr = 1'b1;
    tick();
    u_if.ovf_clr = 1'b0;
    n_cmp++;
    if (u_if.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: got %b want 0", u_if.ovf);
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'h20 + 8'(i), 1'b1, 1'b1);
    end
    drive(8'h24, 1'b1, 1'b1);
    u_if.out_ready = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    u_if.out_ready = 1'b0;
    n_cmp++;
    if (u_if.level !== 3'd4 || u_if.out_data !== 8'h21 || u_if.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop: got lvl=%0d d=%h o=%b want lvl=4 d=21 o=0",
               u_if.level, u_if.out_data, u_if.ovf);
    end
    drive(8'h25, 1'b1, 1'b1);
    u_if.ovf_clr = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    u_if.ovf_clr = 1'b0;
    n_cmp++;
    if (u_if.ovf !== 1'b1 || u_if.level !== 3'd4 || u_if.out_data !== 8'h21) begin
      n_err++;
      $display("FAIL ovf_set_wins: got o=%b lvl=%0d d=%h want o=1 lvl=4 d=21",
               u_if.ovf, u_if.level, u_if.out_data);
    end
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.out_data !== 8'h21) begin
      n_err++;
      $display("FAIL hold_stable: got %h want 21", u_if.out_data);
    end
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (u_if.out_data !== 8'h21 + 8'(k)) begin
        n_err++;
        $display("FAIL full_order[%0d]: got %h want %h", k, u_if.out_data, 8'h21 + 8'(k));
      end
      tick();
    end
    u_if.out_ready = 1'b0;
    u_if.ovf_clr   = 1'b1;
    tick();
    u_if.ovf_clr   = 1'b0;
  endtask

  task automatic test_cmp_same_edge();
    u_if.cmp_we   = 1'b1;
    u_if.cmp_data = 8'h00;
    drive(8'h00, 1'b0, 1'b0);
    u_if.cmp_we   = 1'b0;
    drive(8'h05, 1'b1, 1'b0);
    u_if.cmp_we   = 1'b1;
    u_if.cmp_data = 8'h05;
    drive(8'h00, 1'b0, 1'b0);
    u_if.cmp_we   = 1'b0;
    n_cmp++;
    if (u_if.match !== 1'b0) begin
      n_err++;
      $display("FAIL cmp_old_value: got %b want 0", u_if.match);
    end
    drive(8'h05, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.match !== 1'b1) begin
      n_err++;
      $display("FAIL cmp_new_value: got %b want 1", u_if.match);
    end
    u_if.cmp_we   = 1'b1;
    u_if.cmp_data = 8'h09;
    drive(8'h00, 1'b0, 1'b0);
    u_if.cmp_data = 8'h06;
    drive(8'h00, 1'b0, 1'b0);
    u_if.cmp_we   = 1'b0;
    drive(8'h06, 1'b1, 1'b0);
    drive(8'h09, 1'b1, 1'b0);
    n_cmp++;
    if (u_if.match !== 1'b1) begin
      n_err++;
      $display("FAIL cmp_last_wins: got %b want 1", u_if.match);
    end
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.match !== 1'b0) begin
      n_err++;
      $display("FAIL cmp_first_lost: got %b want 0", u_if.match);
    end
  endtask

  task automatic test_reset_midstream();
    drive(8'h30, 1'b1, 1'b1);
    drive(8'h31, 1'b1, 1'b1);
    drive(8'h32, 1'b1, 1'b1);
    drive(8'hFF, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.level !== 3'd3) begin
      n_err++;
      $display("FAIL mid_fill: got lvl=%0d want 3", u_if.level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.out_valid, u_if.level, u_if.ovf, u_if.match} !== 6'd0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b lvl=%0d o=%b m=%b want all 0",
               u_if.out_valid, u_if.level, u_if.ovf, u_if.match);
    end
    tick();
    rst_n = 1'b1;
    drive(8'h00, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.wrap !== 1'b0 || u_if.level !== 3'd0) begin
      n_err++;
      $display("FAIL post_reset_no_wrap: got w=%b lvl=%0d want w=0 lvl=0",
               u_if.wrap, u_if.level);
    end
    drive(8'hFF, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (u_if.wrap !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_early: got %b want 0", u_if.wrap);
    end
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (u_if.wrap !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_wrap: got %b want 1", u_if.wrap);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_gap_and_load();
    test_overflow();
    test_full_pushpop();
    test_cmp_same_edge();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
